// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: decodes a UART command byte, hands the shared UART TX to one responder until it is done.
// Optional build macro CMD_ECHO_EN: echo each accepted command byte on TX before dispatching it.
module uart_cmd_dispatcher #(
    parameter int unsigned N_CLIENTS      = 4,
    parameter logic [7:0]  CMD_BASE       = 8'h41,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clk_50mhz,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [N_CLIENTS-1:0]   client_activate,
    input  logic [N_CLIENTS-1:0]   client_done,
    input  logic [8*N_CLIENTS-1:0] client_tx_data,
    input  logic [N_CLIENTS-1:0]   client_tx_start,
    input  logic                   tx_active,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   busy,
    output logic [3:0]             active_sel,
    output logic                   cmd_error,
    output logic                   timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef CMD_ECHO_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ECHO_SEND, S_ECHO_HOLD, S_ECHO_WAIT, S_ACTIVE, S_RELEASE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ACTIVE, S_RELEASE
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_sel;
    logic [3:0]             w_sel_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [N_CLIENTS-1:0]   r_activate;
    logic [N_CLIENTS-1:0]   w_act_nxt;
    logic                   r_busy;
    logic                   r_cmd_error;
    logic                   w_cmd_error_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
    logic [7:0]             w_idx;
    logic                   w_idx_ok;
    logic                   w_sel_done;
    logic                   w_sel_start;
    logic [7:0]             w_sel_data;

`ifdef CMD_ECHO_EN
    logic [7:0]             r_cmd;
`else
    logic                   w_unused_tx_active;
    assign w_unused_tx_active = tx_active;
`endif

    // Command byte to client index; wraps below CMD_BASE so those bytes are rejected too
    assign w_idx    = rx_data - CMD_BASE;
    assign w_idx_ok = (w_idx < 8'(N_CLIENTS));

    // Pick the owning client's responder signals
    always_comb begin
        w_sel_done  = 1'b0;
        w_sel_start = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (r_sel == 4'(i)) begin
                w_sel_done  = client_done[i];
                w_sel_start = client_tx_start[i];
                w_sel_data  = client_tx_data[8*i +: 8];
            end
        end
    end

    // Next-state, TX mux and pulse decode
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_cnt_nxt       = r_cnt;
        w_cmd_error_nxt = rx_valid && (r_state != S_IDLE);
        w_timeout_nxt   = 1'b0;
        w_act_nxt       = '0;
        tx_data         = '0;
        tx_start        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (w_idx_ok) begin
                        w_sel_nxt = w_idx[3:0];
`ifdef CMD_ECHO_EN
                        w_state_nxt = S_ECHO_SEND;
`else
                        w_state_nxt = S_ACTIVE;
`endif
                    end else begin
                        w_cmd_error_nxt = 1'b1;
                    end
                end
            end
`ifdef CMD_ECHO_EN
            S_ECHO_SEND: begin
                tx_data     = r_cmd;
                tx_start    = 1'b1;
                w_state_nxt = S_ECHO_HOLD;
            end
            S_ECHO_HOLD: begin
                tx_data     = r_cmd;
                w_state_nxt = S_ECHO_WAIT;
            end
            S_ECHO_WAIT: begin
                tx_data = r_cmd;
                if (!tx_active) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
`endif
            S_ACTIVE: begin
                tx_data  = w_sel_data;
                tx_start = w_sel_start;
                if (w_sel_done) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
                    w_state_nxt   = S_RELEASE;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                w_cnt_nxt = '0;
                if (!w_sel_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_state_nxt == S_ACTIVE) begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                w_act_nxt[i] = (w_sel_nxt == 4'(i));
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_activate  <= '0;
            r_busy      <= 1'b0;
            r_cmd_error <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_activate  <= w_act_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_cmd_error <= w_cmd_error_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

`ifdef CMD_ECHO_EN
    // Latch the command byte for the echo
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            r_cmd <= '0;
        end else if ((r_state == S_IDLE) && rx_valid) begin
            r_cmd <= rx_data;
        end
    end
`endif

    assign client_activate = r_activate;
    assign busy            = r_busy;
    assign active_sel      = r_sel;
    assign cmd_error       = r_cmd_error;
    assign timeout         = r_timeout;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Bench for uart_cmd_dispatcher: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level ownership model. Honours CMD_ECHO_EN if defined.
module tb_uart_cmd_dispatcher;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'h41;
    localparam int         TO   = 100;
`ifdef CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic           clk_50mhz = 1'b0;
    logic           reset = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_valid = 1'b0;
    logic [N-1:0]   client_activate;
    logic [N-1:0]   client_done = '0;
    logic [8*N-1:0] client_tx_data = '0;
    logic [N-1:0]   client_tx_start = '0;
    logic           tx_active = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           busy;
    logic [3:0]     active_sel;
    logic           cmd_error;
    logic           timeout;

    int n_vec = 0;
    int n_err = 0;

    uart_cmd_dispatcher #(
        .N_CLIENTS      (N),
        .CMD_BASE       (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50mhz       (clk_50mhz),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .client_activate (client_activate),
        .client_done     (client_done),
        .client_tx_data  (client_tx_data),
        .client_tx_start (client_tx_start),
        .tx_active       (tx_active),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .busy            (busy),
        .active_sel      (active_sel),
        .cmd_error       (cmd_error),
        .timeout         (timeout)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the TX, how long it has served, whether it is draining.
    // m_echo: 0 = no echo pending, 1 = echo byte going out, 2 = gap cycle, 3 = waiting for TX idle.
    int         m_owner  = -1;
    int         m_sel    = 0;
    bit         m_drain  = 1'b0;
    int         m_echo   = 0;
    int         m_served = 0;
    logic [7:0] m_cmd    = '0;
    bit         m_err    = 1'b0;
    bit         m_to     = 1'b0;
    int         m_idx;

    always @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            m_owner = -1; m_sel = 0; m_drain = 1'b0; m_echo = 0;
            m_served = 0; m_err = 1'b0; m_to = 1'b0;
        end else begin
            m_err = rx_valid && (m_owner >= 0);
            m_to  = 1'b0;
            if (m_owner < 0) begin
                if (rx_valid) begin
                    m_idx = (int'(rx_data) - int'(BASE) + 256) % 256;
                    if (m_idx < N) begin
                        m_owner = m_idx; m_sel = m_idx; m_cmd = rx_data;
                        m_drain = 1'b0; m_served = 0; m_echo = ECHO ? 1 : 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_drain) begin
                if (!client_done[m_owner]) m_owner = -1;
            end else if (m_echo == 3) begin
                if (!tx_active) m_echo = 0;
            end else if (m_echo != 0) begin
                m_echo++;
            end else begin
                m_served++;
                if (client_done[m_owner]) m_drain = 1'b1;
                else if (TO != 0 && m_served == TO) begin
                    m_to = 1'b1; m_drain = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_50mhz) begin : compare
        logic [N-1:0] e_act;
        logic [7:0]   e_data;
        logic         e_start;
        bit           serving;
        serving = (m_owner >= 0) && !m_drain && (m_echo == 0);
        e_act   = serving ? (N'(1) << m_owner) : '0;
        e_data  = '0;
        e_start = 1'b0;
        if (serving) begin
            e_data  = client_tx_data[8*m_owner +: 8];
            e_start = client_tx_start[m_owner];
        end else if (m_owner >= 0 && m_echo == 1) begin
            e_data  = m_cmd;
            e_start = 1'b1;
        end
        chk("busy", busy, m_owner >= 0);
        if (m_owner >= 0) chk("active_sel", active_sel, m_sel);
        chk("client_activate", client_activate, e_act);
        chk("cmd_error", cmd_error, m_err);
        chk("timeout", timeout, m_to);
        chk("tx_start", tx_start, e_start);
        if (!(m_owner >= 0 && (m_echo == 2 || m_echo == 3))) chk("tx_data", tx_data, e_data);
    end

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_50mhz);
    endtask

    // Send an accepted command and walk it to the first ACTIVE cycle
    task automatic accept(input logic [7:0] c, input int idx);
        rx_data = c; rx_valid = 1'b1; tx_active = 1'b1;
        tick();
        rx_valid = 1'b0;
`ifdef CMD_ECHO_EN
        at_neg();
        chk("echo_tx_start", tx_start, 1);
        chk("echo_tx_data", tx_data, c);
        chk("echo_activate", client_activate, 0);
        tick(); at_neg();
        chk("echo_gap_start", tx_start, 0);
        tick(); at_neg();
        chk("echo_wait_activate", client_activate, 0);
        tick();
        tx_active = 1'b0;
        at_neg();
        chk("echo_fall_activate", client_activate, 0);
        tick();
`else
        tx_active = 1'b0;
`endif
        at_neg();
        chk("accept_activate", client_activate, 32'(1) << idx);
        chk("accept_busy", busy, 1);
        chk("accept_sel", active_sel, idx);
        tick();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] bytes [4];
        logic [7:0] bad [2];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        bad[0] = 8'h7F; bad[1] = 8'h40;

        tick(); tick(); at_neg();
        chk("reset_activate", client_activate, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tx_start", tx_start, 0);
        tick();
        reset = 1'b1;
        tick();

        // Client 1 owns TX and streams four bytes
        accept(8'h42, 1);
        foreach (bytes[i]) begin
            client_tx_data[15:8] = bytes[i]; client_tx_start[1] = 1'b1;
            at_neg();
            chk("stream_data", tx_data, bytes[i]);
            chk("stream_start", tx_start, 1);
            tick();
            client_tx_start = '0;
            at_neg();
            chk("stream_gap", tx_start, 0);
            tick();
        end

        // Done handshake releases the TX
        client_done[1] = 1'b1;
        tick(); at_neg();
        chk("done_activate", client_activate, 0);
        chk("done_busy", busy, 1);
        tick();
        client_done[1] = 1'b0;
        at_neg();
        chk("drain_busy", busy, 1);
        tick(); at_neg();
        chk("idle_busy", busy, 0);
        tick();

        // Unknown commands in IDLE
        foreach (bad[i]) begin
            rx_data = bad[i]; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            at_neg();
            chk("bad_cmd_error", cmd_error, 1);
            chk("bad_activate", client_activate, 0);
            tick(); at_neg();
            chk("bad_cmd_error_end", cmd_error, 0);
            tick();
        end

        // Command dropped while client 2 is active; foreign tx_start ignored
        accept(8'h43, 2);
        rx_data = 8'h41; rx_valid = 1'b1; client_tx_start = 4'b0001;
        at_neg();
        chk("foreign_tx_start", tx_start, 0);
        tick();
        rx_valid = 1'b0; client_tx_start = '0;
        at_neg();
        chk("drop_cmd_error", cmd_error, 1);
        chk("drop_activate", client_activate, 4'b0100);
        chk("drop_sel", active_sel, 2);
        client_done[2] = 1'b1;
        tick(); tick();
        client_done[2] = 1'b0;
        tick(); tick();

        // Timeout after exactly TO active cycles
        accept(8'h41, 0);
        repeat (TO - 2) tick();
        at_neg();
        chk("pre_timeout_activate", client_activate, 4'b0001);
        chk("pre_timeout_pulse", timeout, 0);
        tick(); at_neg();
        chk("timeout_pulse", timeout, 1);
        chk("timeout_activate", client_activate, 0);
        tick(); at_neg();
        chk("timeout_pulse_end", timeout, 0);
        chk("timeout_idle", busy, 0);
        tick();

        // Asynchronous reset mid-transaction
        accept(8'h42, 1);
        client_tx_data[15:8] = 8'hA5; client_tx_start[1] = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("areset_activate", client_activate, 0);
        chk("areset_busy", busy, 0);
        chk("areset_tx_start", tx_start, 0);
        chk("areset_tx_data", tx_data, 0);
        tick();
        client_tx_start = '0; client_tx_data = '0;
        reset = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rx_valid        = ($urandom_range(0, 5) == 0);
            rx_data         = ($urandom_range(0, 3) != 0) ? 8'(BASE + $urandom_range(0, 6) - 1)
                                                           : 8'($urandom);
            client_tx_data  = 32'($urandom);
            client_tx_start = N'($urandom);
            tx_active       = ($urandom_range(0, 2) != 0);
            if (c >= 1500 && c < 2200) client_done = '0;
            else client_done = N'($urandom) & N'($urandom) & N'($urandom);
            if (c == 3000) reset = 1'b0;
            if (c == 3003) reset = 1'b1;
            tick();
        end

        rx_valid = 1'b0; client_done = '0; client_tx_start = '0; tx_active = 1'b0;
        repeat (4) tick();
        at_neg();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
